// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the glitch-free divided-clock controller.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 3;
  localparam int DEFAULT_DIV_DEF = 7;
  localparam int CHG_CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration handshake between the config register block and the divider controller.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 3
);

  logic             i_cfg_valid;
  logic [CNT_W-1:0] i_cfg_div;
  logic             o_cfg_ready;
  logic             o_cfg_err;

  modport master (
    output i_cfg_valid,
    output i_cfg_div,
    input  o_cfg_ready,
    input  o_cfg_err
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_div,
    output o_cfg_ready,
    output o_cfg_err
  );

endinterface

// File: rtl/clk_div_core.sv
// Divide counter and output toggle flop; clr wins over en and parks the clock low.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] ratio,
  output logic             count_end,
  output logic             div_clk
);

  logic [CNT_W-1:0] count;

  assign count_end = en && !clr && (count == (ratio - CNT_W'(1)));

  // counter wraps at ratio-1 and toggles the divided clock on that same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= {CNT_W{1'b0}};
      div_clk <= 1'b0;
    end else if (clr) begin
      count   <= {CNT_W{1'b0}};
      div_clk <= 1'b0;
    end else if (count_end) begin
      count   <= {CNT_W{1'b0}};
      div_clk <= ~div_clk;
    end else if (en) begin
      count   <= count + CNT_W'(1);
      div_clk <= div_clk;
    end else begin
      count   <= count;
      div_clk <= div_clk;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio-change sequencer; every change lands on a falling edge of o_div_clk.
// Optional CLK_DIV_CTRL_CHG_CNT_EN adds o_chg_cnt, a wrapping count of applied ratio changes.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  clk_div_ctrl_if.slave    cfg,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_ratio
`ifdef CLK_DIV_CTRL_CHG_CNT_EN
  ,
  output logic [CHG_CNT_W-1:0] o_chg_cnt
`endif
);

  state_t           state;
  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] ratio_nxt;
  logic             pend_vld;
  logic             ready;
  logic             err;
  logic             tick;
  logic             busy;
  logic             ratio_load;
  logic             accept;
  logic             new_cfg;
  logic             cfg_zero;
  logic             stop_req;
  logic             stop_done;
  logic             fall_edge;
  logic             core_en;
  logic             core_clr;
  logic             count_end;
  logic             div_clk;

  assign accept    = cfg.i_cfg_valid && ready;
  assign cfg_zero  = accept && (cfg.i_cfg_div == {CNT_W{1'b0}});
  assign new_cfg   = accept && (cfg.i_cfg_div != {CNT_W{1'b0}});
  assign stop_req  = ((state == RUN) || (state == DRAIN)) && !i_run;
  assign fall_edge = div_clk && count_end;
  // a stop with the clock already low, or landing on its falling edge, reaches IDLE at once
  assign stop_done = stop_req && (!div_clk || fall_edge);
  assign core_en   = (state != IDLE);
  assign core_clr  = (state == IDLE) || (stop_req && !div_clk);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (core_en),
    .clr       (core_clr),
    .ratio     (ratio),
    .count_end (count_end),
    .div_clk   (div_clk)
  );

  // picks the ratio to apply at this edge, if any
  always_comb begin
    ratio_load = 1'b0;
    ratio_nxt  = ratio;
    case (state)
      IDLE: begin
        if (new_cfg) begin
          ratio_load = 1'b1;
          ratio_nxt  = cfg.i_cfg_div;
        end else begin
          ratio_load = 1'b0;
        end
      end
      RUN, DRAIN: begin
        if (stop_done && new_cfg) begin
          ratio_load = 1'b1;
          ratio_nxt  = cfg.i_cfg_div;
        end else if ((stop_done || ((state == DRAIN) && fall_edge)) && pend_vld) begin
          ratio_load = 1'b1;
          ratio_nxt  = pend;
        end else begin
          ratio_load = 1'b0;
        end
      end
      STOP: begin
        if (fall_edge && pend_vld) begin
          ratio_load = 1'b1;
          ratio_nxt  = pend;
        end else begin
          ratio_load = 1'b0;
        end
      end
      default: begin
        ratio_load = 1'b0;
      end
    endcase
  end

  // control FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ratio    <= CNT_W'(DEFAULT_DIV);
      pend     <= {CNT_W{1'b0}};
      pend_vld <= 1'b0;
      ready    <= 1'b1;
      err      <= 1'b0;
      tick     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tick <= count_end;
      err  <= cfg_zero;
      if (ratio_load) begin
        ratio <= ratio_nxt;
      end else begin
        ratio <= ratio;
      end
      case (state)
        IDLE: begin
          pend_vld <= 1'b0;
          ready    <= 1'b1;
          if (i_run) begin
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN, DRAIN: begin
          if (stop_done) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ready    <= 1'b1;
            pend_vld <= 1'b0;
          end else if (stop_req) begin
            state <= STOP;
            busy  <= 1'b1;
            ready <= 1'b0;
            if (new_cfg) begin
              pend     <= cfg.i_cfg_div;
              pend_vld <= 1'b1;
            end else begin
              pend_vld <= pend_vld;
            end
          end else if ((state == DRAIN) && fall_edge) begin
            state    <= RUN;
            busy     <= 1'b1;
            ready    <= 1'b1;
            pend_vld <= 1'b0;
          end else if (new_cfg) begin
            state    <= DRAIN;
            busy     <= 1'b1;
            ready    <= 1'b0;
            pend     <= cfg.i_cfg_div;
            pend_vld <= 1'b1;
          end else begin
            state <= state;
            busy  <= 1'b1;
            ready <= (state == RUN);
          end
        end
        STOP: begin
          if (fall_edge) begin
            state    <= IDLE;
            busy     <= 1'b0;
            ready    <= 1'b1;
            pend_vld <= 1'b0;
          end else begin
            state <= STOP;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ready    <= 1'b1;
          pend_vld <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_CTRL_CHG_CNT_EN
  logic [CHG_CNT_W-1:0] chg_cnt;

  // counts every applied ratio change, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chg_cnt <= {CHG_CNT_W{1'b0}};
    end else if (ratio_load) begin
      chg_cnt <= chg_cnt + CHG_CNT_W'(1);
    end else begin
      chg_cnt <= chg_cnt;
    end
  end

  assign o_chg_cnt = chg_cnt;
`endif

  assign cfg.o_cfg_ready = ready;
  assign cfg.o_cfg_err   = err;
  assign o_div_clk       = div_clk;
  assign o_tick          = tick;
  assign o_busy          = busy;
  assign o_ratio         = ratio;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: start, ratio change, zero ratio, stop, N=1, reset.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_run;
  logic       o_div_clk;
  logic       o_tick;
  logic       o_busy;
  logic [2:0] o_ratio;
`ifdef CLK_DIV_CTRL_CHG_CNT_EN
  logic [7:0] o_chg_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int n;

  clk_div_ctrl_if #(.CNT_W(3)) cfg_if ();

  clk_div_ctrl #(
    .CNT_W       (3),
    .DEFAULT_DIV (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_run     (i_run),
    .cfg       (cfg_if),
    .o_div_clk (o_div_clk),
    .o_tick    (o_tick),
    .o_busy    (o_busy),
    .o_ratio   (o_ratio)
`ifdef CLK_DIV_CTRL_CHG_CNT_EN
    ,
    .o_chg_cnt (o_chg_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // steps until o_div_clk reaches lvl; returns the number of clock edges taken (capped)
  task automatic wait_clk(input logic lvl, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while ((o_div_clk !== lvl) && (cnt < 40));
  endtask

  initial begin
    reset              = 1'b1;
    i_run              = 1'b0;
    cfg_if.i_cfg_valid = 1'b0;
    cfg_if.i_cfg_div   = 3'd0;
    step();
    step();
    chk("rst_div_clk", o_div_clk, 32'd0);
    chk("rst_tick", o_tick, 32'd0);
    chk("rst_err", cfg_if.o_cfg_err, 32'd0);
    chk("rst_busy", o_busy, 32'd0);
    chk("rst_ready", cfg_if.o_cfg_ready, 32'd1);
    chk("rst_ratio", o_ratio, 32'd7);

    // 1: start with N=7
    reset = 1'b0;
    i_run = 1'b1;
    step();
    chk("t1_busy", o_busy, 32'd1);
    chk("t1_div_low", o_div_clk, 32'd0);
    wait_clk(1'b1, n);
    chk("t1_first_rise", n, 32'd7);
    chk("t1_tick_on_rise", o_tick, 32'd1);
    step();
    chk("t1_tick_pulse", o_tick, 32'd0);
    wait_clk(1'b0, n);
    chk("t1_high", n, 32'd6);
    chk("t1_tick_on_fall", o_tick, 32'd1);
    wait_clk(1'b1, n);
    chk("t1_low", n, 32'd7);

    // 2: ratio 3 requested mid high phase
    step();
    step();
    chk("t2_ready_before", cfg_if.o_cfg_ready, 32'd1);
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_div   = 3'd3;
    step();
    cfg_if.i_cfg_valid = 1'b0;
    chk("t2_ready_drain", cfg_if.o_cfg_ready, 32'd0);
    chk("t2_ratio_old", o_ratio, 32'd7);
    wait_clk(1'b0, n);
    chk("t2_high_finish", n, 32'd4);
    chk("t2_ratio_new", o_ratio, 32'd3);
    chk("t2_ready_after", cfg_if.o_cfg_ready, 32'd1);
    wait_clk(1'b1, n);
    chk("t2_low3", n, 32'd3);
    wait_clk(1'b0, n);
    chk("t2_high3", n, 32'd3);

    // back to 7 via DRAIN, requested at the start of a low phase
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_div   = 3'd7;
    step();
    cfg_if.i_cfg_valid = 1'b0;
    wait_clk(1'b1, n);
    chk("t3_pre_low", n, 32'd2);
    wait_clk(1'b0, n);
    chk("t3_pre_high", n, 32'd3);
    chk("t3_pre_ratio", o_ratio, 32'd7);

    // 3: zero ratio is discarded with an error pulse
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_div   = 3'd0;
    step();
    cfg_if.i_cfg_valid = 1'b0;
    chk("t3_err_pulse", cfg_if.o_cfg_err, 32'd1);
    chk("t3_ratio_kept", o_ratio, 32'd7);
    chk("t3_ready_kept", cfg_if.o_cfg_ready, 32'd1);
    step();
    chk("t3_err_clear", cfg_if.o_cfg_err, 32'd0);
    wait_clk(1'b1, n);
    chk("t3_low_rest", n, 32'd5);
    wait_clk(1'b0, n);
    chk("t3_high", n, 32'd7);

    // 4: stop during the high phase
    wait_clk(1'b1, n);
    chk("t4_low", n, 32'd7);
    step();
    step();
    i_run = 1'b0;
    step();
    chk("t4_stop_busy", o_busy, 32'd1);
    chk("t4_stop_high", o_div_clk, 32'd1);
    chk("t4_stop_ready", cfg_if.o_cfg_ready, 32'd0);
    wait_clk(1'b0, n);
    chk("t4_stop_fall", n, 32'd4);
    chk("t4_idle_busy", o_busy, 32'd0);
    chk("t4_idle_ready", cfg_if.o_cfg_ready, 32'd1);
    step();
    step();
    step();
    chk("t4_idle_div", o_div_clk, 32'd0);
    chk("t4_idle_tick", o_tick, 32'd0);

    // stop during the low phase goes straight to IDLE
    i_run = 1'b1;
    step();
    step();
    i_run = 1'b0;
    step();
    chk("t4b_idle_busy", o_busy, 32'd0);
    chk("t4b_idle_div", o_div_clk, 32'd0);

    // 5: N=1 loaded in IDLE
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_div   = 3'd1;
    step();
    cfg_if.i_cfg_valid = 1'b0;
    chk("t5_ratio", o_ratio, 32'd1);
    chk("t5_busy_idle", o_busy, 32'd0);
    i_run = 1'b1;
    step();
    wait_clk(1'b1, n);
    chk("t5_rise", n, 32'd1);
    wait_clk(1'b0, n);
    chk("t5_fall", n, 32'd1);
    chk("t5_tick", o_tick, 32'd1);
    wait_clk(1'b1, n);
    chk("t5_rise2", n, 32'd1);

    // 6: reset in the middle of DRAIN
    cfg_if.i_cfg_valid = 1'b1;
    cfg_if.i_cfg_div   = 3'd5;
    step();
    cfg_if.i_cfg_valid = 1'b0;
    chk("t6_drain_ready", cfg_if.o_cfg_ready, 32'd0);
    chk("t6_drain_busy", o_busy, 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_div_clk", o_div_clk, 32'd0);
    chk("t6_tick", o_tick, 32'd0);
    chk("t6_err", cfg_if.o_cfg_err, 32'd0);
    chk("t6_busy", o_busy, 32'd0);
    chk("t6_ready", cfg_if.o_cfg_ready, 32'd1);
    chk("t6_ratio", o_ratio, 32'd7);
    step();
    reset = 1'b0;
    step();
    chk("t6_post_busy", o_busy, 32'd1);
    wait_clk(1'b1, n);
    chk("t6_post_rise", n, 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
